// File: rtl/shift_load_arb.sv
// Round-robin sequencer that loads a granted requester word into an external
// serial-in shift register, LSB first, and strobes frame_valid when it is in place.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request; arbitration happens on each edge here
// S_SHIFT | driving hold[0] on sx for WIDTH cycles
// S_GAP   | forced idle spacing of GAP_CYCLES cycles after a frame
module shift_load_arb #(
   parameter int WIDTH      = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] din0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] din1,
   output logic             ack1,
   output logic             sx,
   output logic             busy,
   output logic             frame_valid,
   output logic             frame_owner
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_hold;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [3:0]       r_gap_cnt;
   logic             r_last_grant;
   logic             r_cur_owner;
   logic             r_frame_owner;
   logic             r_frame_valid;
   logic             r_ack0;
   logic             r_ack1;

   logic             w_grant;
   logic             w_grant_idx;
   logic             w_last_bit;
   logic             w_gap_done;

   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = 1'b0;
      if (req0 && req1) begin
         w_grant     = 1'b1;
         w_grant_idx = ~r_last_grant;
      end else if (req0) begin
         w_grant     = 1'b1;
         w_grant_idx = 1'b0;
      end else if (req1) begin
         w_grant     = 1'b1;
         w_grant_idx = 1'b1;
      end
   end

   assign w_last_bit = (r_bit_cnt == CNT_LAST);
   assign w_gap_done = (r_gap_cnt == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_SHIFT;
         S_SHIFT: if (w_last_bit) w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
         S_GAP:   if (w_gap_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath; ack and frame_valid default low so they can only ever pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold        <= '0;
         r_bit_cnt     <= '0;
         r_gap_cnt     <= 4'd0;
         r_last_grant  <= 1'b1;
         r_cur_owner   <= 1'b0;
         r_frame_owner <= 1'b0;
         r_frame_valid <= 1'b0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
      end else begin
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_frame_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_hold       <= w_grant_idx ? din1 : din0;
                  r_cur_owner  <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_bit_cnt    <= '0;
                  r_ack0       <= ~w_grant_idx;
                  r_ack1       <= w_grant_idx;
               end
            end
            S_SHIFT: begin
               r_hold    <= {1'b0, r_hold[WIDTH-1:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
               if (w_last_bit) begin
                  r_frame_valid <= 1'b1;
                  r_frame_owner <= r_cur_owner;
                  r_gap_cnt     <= GAP_LOAD;
               end
            end
            S_GAP: begin
               if (!w_gap_done) r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sx          = (r_state == S_SHIFT) ? r_hold[0] : 1'b0;
   assign busy        = (r_state != S_IDLE);
   assign ack0        = r_ack0;
   assign ack1        = r_ack1;
   assign frame_valid = r_frame_valid;
   assign frame_owner = r_frame_owner;

endmodule
